// File: rtl/l2_cache_arb_sched_if.sv
// Request/response bundle between the L2 requesters (core, system-memory restart) and the arbiter front stage.
// master = requester/pipeline side, slave = arbiter.
interface l2_cache_arb_sched_if;
    logic         stall_pipeline;
    logic         pci_valid;
    logic [612:0] pci_request;
    logic         pci_ack;
    logic         smi_valid;
    logic [612:0] smi_request;
    logic [511:0] smi_data;
    logic [1:0]   smi_fill_l2_way;
    logic         smi_ack;
    logic         arb_l2req_valid;
    logic [612:0] arb_l2req;
    logic         arb_has_sm_data;
    logic [511:0] arb_sm_data;
    logic [1:0]   arb_sm_fill_l2_way;

    modport master (
        output stall_pipeline, pci_valid, pci_request, smi_valid, smi_request, smi_data, smi_fill_l2_way,
        input  pci_ack, smi_ack, arb_l2req_valid, arb_l2req, arb_has_sm_data, arb_sm_data, arb_sm_fill_l2_way
    );
    modport slave (
        input  stall_pipeline, pci_valid, pci_request, smi_valid, smi_request, smi_data, smi_fill_l2_way,
        output pci_ack, smi_ack, arb_l2req_valid, arb_l2req, arb_has_sm_data, arb_sm_data, arb_sm_fill_l2_way
    );
endinterface

// File: rtl/l2_cache_arb_sched.sv
// L2 front-stage arbiter: restarts (memory fills) win over core requests, bounded by a starvation counter.
// Optional macro L2_ARB_PERF_EN adds free-running grant/starvation performance counters.
module l2_cache_arb_sched #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    l2_cache_arb_sched_if.slave      bus
`ifdef L2_ARB_PERF_EN
    ,
    output logic [31:0]              perf_restart_grants,
    output logic [31:0]              perf_core_grants,
    output logic [31:0]              perf_starve_events
`endif
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       starve_hit;
    logic       grant_r;
    logic       grant_c;
    logic       live;

    // Acks are suppressed while reset is asserted so nothing is consumed that the pipeline will drop.
    assign live       = reset_n && !bus.stall_pipeline;
    assign starve_hit = bus.pci_valid && (starve_cnt == LIMIT);
    assign grant_r    = live && bus.smi_valid && !starve_hit;
    assign grant_c    = live && bus.pci_valid && !grant_r;

    assign bus.smi_ack = grant_r;
    assign bus.pci_ack = grant_c;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_cnt             <= '0;
            bus.arb_l2req_valid    <= 1'b0;
            bus.arb_l2req          <= '0;
            bus.arb_has_sm_data    <= 1'b0;
            bus.arb_sm_data        <= '0;
            bus.arb_sm_fill_l2_way <= '0;
        end else if (!bus.stall_pipeline) begin
            if (grant_r) begin
                bus.arb_l2req_valid    <= 1'b1;
                bus.arb_l2req          <= bus.smi_request;
                bus.arb_has_sm_data    <= 1'b1;
                bus.arb_sm_data        <= bus.smi_data;
                bus.arb_sm_fill_l2_way <= bus.smi_fill_l2_way;
            end else if (grant_c) begin
                bus.arb_l2req_valid    <= 1'b1;
                bus.arb_l2req          <= bus.pci_request;
                bus.arb_has_sm_data    <= 1'b0;
                bus.arb_sm_data        <= '0;
                bus.arb_sm_fill_l2_way <= '0;
            end else begin
                bus.arb_l2req_valid    <= 1'b0;
                bus.arb_has_sm_data    <= 1'b0;
            end
            // Count only restart wins that actually deferred a waiting core request.
            if (grant_r && bus.pci_valid)
                starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
            else
                starve_cnt <= '0;
        end
    end

`ifdef L2_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_restart_grants <= '0;
            perf_core_grants    <= '0;
            perf_starve_events  <= '0;
        end else begin
            if (grant_r) perf_restart_grants <= perf_restart_grants + 32'd1;
            if (grant_c) perf_core_grants    <= perf_core_grants + 32'd1;
            if (grant_c && starve_hit) perf_starve_events <= perf_starve_events + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_l2_cache_arb_sched.sv
// Bench for l2_cache_arb_sched: vector table, directed payload checks, random traffic against a reference model.
module tb_l2_cache_arb_sched;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    l2_cache_arb_sched_if bus();
`ifdef L2_ARB_PERF_EN
    logic [31:0] perf_r, perf_c, perf_s;
`endif

    l2_cache_arb_sched #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
`ifdef L2_ARB_PERF_EN
        , .perf_restart_grants(perf_r), .perf_core_grants(perf_c), .perf_starve_events(perf_s)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic         m_valid, m_has;
    logic [612:0] m_req;
    logic [511:0] m_data;
    logic [1:0]   m_way;
    int           m_wait;
    logic [31:0]  m_pr, m_pc, m_ps;

    typedef struct {
        bit rst_n, stall, pv, sv;
        bit e_pa, e_sa;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [612:0] act, input logic [612:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [612:0] rnd_req();
        logic [612:0] v = '0;
        for (int i = 0; i < 20; i++) v = (v << 32) | 613'($urandom());
        return v;
    endfunction

    function automatic logic [511:0] rnd_data();
        logic [511:0] v = '0;
        for (int i = 0; i < 16; i++) v = (v << 32) | 512'($urandom());
        return v;
    endfunction

    task automatic drive(input bit rst_n, input bit stall, input bit pv, input logic [612:0] preq,
                         input bit sv, input logic [612:0] sreq, input logic [511:0] sdata, input logic [1:0] sway);
        reset_n             = rst_n;
        bus.stall_pipeline  = stall;
        bus.pci_valid       = pv;
        bus.pci_request     = preq;
        bus.smi_valid       = sv;
        bus.smi_request     = sreq;
        bus.smi_data        = sdata;
        bus.smi_fill_l2_way = sway;
    endtask

    // One clock: check acks against the model, advance the model, check registered outputs after the edge.
    task automatic cycle(output bit pa, output bit sa);
        bit e_pa, e_sa, starved;
        e_pa = 0; e_sa = 0; starved = 0;
        #1;
        if (reset_n && !bus.stall_pipeline) begin
            starved = bus.pci_valid && (m_wait >= LIMIT);
            if (bus.smi_valid && !starved) e_sa = 1;
            else if (bus.pci_valid)        e_pa = 1;
        end
        chk("pci_ack", 613'(bus.pci_ack), 613'(e_pa));
        chk("smi_ack", 613'(bus.smi_ack), 613'(e_sa));
        pa = bus.pci_ack;
        sa = bus.smi_ack;
        if (!reset_n) begin
            m_valid = 0; m_has = 0; m_req = '0; m_data = '0; m_way = '0; m_wait = 0;
            m_pr = 0; m_pc = 0; m_ps = 0;
        end else if (!bus.stall_pipeline) begin
            if (e_sa) begin
                m_valid = 1; m_has = 1; m_req = bus.smi_request;
                m_data = bus.smi_data; m_way = bus.smi_fill_l2_way;
                m_wait = bus.pci_valid ? ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1) : 0;
                m_pr++;
            end else if (e_pa) begin
                m_valid = 1; m_has = 0; m_req = bus.pci_request; m_data = '0; m_way = '0;
                m_wait = 0;
                m_pc++;
                if (starved) m_ps++;
            end else begin
                m_valid = 0; m_has = 0; m_wait = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("arb_l2req_valid", 613'(bus.arb_l2req_valid), 613'(m_valid));
        chk("arb_l2req", bus.arb_l2req, m_req);
        chk("arb_has_sm_data", 613'(bus.arb_has_sm_data), 613'(m_has));
        chk("arb_sm_data", 613'(bus.arb_sm_data), 613'(m_data));
        chk("arb_sm_fill_l2_way", 613'(bus.arb_sm_fill_l2_way), 613'(m_way));
`ifdef L2_ARB_PERF_EN
        chk("perf_restart_grants", 613'(perf_r), 613'(m_pr));
        chk("perf_core_grants", 613'(perf_c), 613'(m_pc));
        chk("perf_starve_events", 613'(perf_s), 613'(m_ps));
`endif
    endtask

    function automatic vec_t mk(bit rst_n, bit stall, bit pv, bit sv, bit e_pa, bit e_sa);
        vec_t v;
        v.rst_n = rst_n; v.stall = stall; v.pv = pv; v.sv = sv; v.e_pa = e_pa; v.e_sa = e_sa;
        return v;
    endfunction

    initial begin
        logic [612:0] preq, sreq;
        logic [511:0] sdata;
        logic [1:0]   sway;
        bit pa, sa, pv, sv, stall, rn;

        m_wait = 0;
        // reset with both valid, then continuous contention, stall, reset mid-stall
        tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) tbl.push_back(mk(1, 0, 1, 1, 0, 1));
            tbl.push_back(mk(1, 0, 1, 1, 1, 0));
        end
        tbl.push_back(mk(1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 1, 0, 1));
        for (int j = 0; j < 3; j++) tbl.push_back(mk(1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0));

        preq = rnd_req(); sreq = rnd_req(); sdata = rnd_data(); sway = 2'($urandom());
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].stall, tbl[i].pv, preq, tbl[i].sv, sreq, sdata, sway);
            cycle(pa, sa);
            chk($sformatf("tbl[%0d].pci_ack", i), 613'(pa), 613'(tbl[i].e_pa));
            chk($sformatf("tbl[%0d].smi_ack", i), 613'(sa), 613'(tbl[i].e_sa));
            if (pa) preq = rnd_req();
            if (sa) begin sreq = rnd_req(); sdata = rnd_data(); sway = 2'($urandom()); end
`ifdef L2_ARB_PERF_EN
            if (i == 11) begin
                chk("perf10_restart", 613'(perf_r), 613'(32'd8));
                chk("perf10_core", 613'(perf_c), 613'(32'd2));
                chk("perf10_starve", 613'(perf_s), 613'(32'd2));
            end
`endif
        end

        // core request alone: address field lands in the registered bundle
        preq = rnd_req();
        preq[601:576] = 26'h0000123;
        drive(1, 0, 1, preq, 0, sreq, sdata, sway);
        cycle(pa, sa);
        chk("core_alone_ack", 613'(pa), 613'(1'b1));
        chk("core_addr", 613'(bus.arb_l2req[601:576]), 613'(26'h0000123));
        chk("core_has_sm", 613'(bus.arb_has_sm_data), 613'(1'b0));

        // restart alone: fill way and data forwarded
        sdata = {64{8'hA5}};
        drive(1, 0, 0, preq, 1, sreq, sdata, 2'd3);
        cycle(pa, sa);
        chk("fill_ack", 613'(sa), 613'(1'b1));
        chk("fill_way", 613'(bus.arb_sm_fill_l2_way), 613'(2'd3));
        chk("fill_data", 613'(bus.arb_sm_data), 613'({64{8'hA5}}));
        chk("fill_has_sm", 613'(bus.arb_has_sm_data), 613'(1'b1));

        // random protocol-respecting traffic
        pv = 0; sv = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pv && ($urandom_range(0, 2) != 0)) begin pv = 1; preq = rnd_req(); end
            if (!sv && ($urandom_range(0, 2) != 0)) begin
                sv = 1; sreq = rnd_req(); sdata = rnd_data(); sway = 2'($urandom());
            end
            stall = ($urandom_range(0, 4) == 0);
            rn    = ($urandom_range(0, 49) != 0);
            drive(rn, stall, pv, preq, sv, sreq, sdata, sway);
            cycle(pa, sa);
            if (pa) pv = 0;
            if (sa) sv = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/l2_cache_arb_sched.md
Name: l2_cache_arb_sched

Overview:
- Front stage of the L2 pipeline. Arbitrates between new core requests and restarted requests, i.e. system-memory fills returning with line data.
- Registers the winner into the arb_l2req_* / arb_has_sm_data / arb_sm_data / arb_sm_fill_l2_way bundle consumed by the tag stage.
- Restarts take priority. A starvation counter bounds how long a waiting core request is deferred.
- Honours the pipeline-wide stall_pipeline.

Parameters:
STARVE_LIMIT, 4, max consecutive restart grants while a core request waits (1..15)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
stall_pipeline  in  1  hold all arb outputs, grant nothing
pci_valid  in  1  core request pending
pci_request  in  613  packed core request {core[2],unit[2],strand[2],op[3],way[2],address[26],data[512],mask[64]}, MSB first
pci_ack  out  1  core request accepted this cycle
smi_valid  in  1  restarted request pending
smi_request  in  613  packed original request, same layout
smi_data  in  512  line fetched from system memory
smi_fill_l2_way  in  2  L2 way to fill
smi_ack  out  1  restarted request accepted this cycle
arb_l2req_valid  out  1  registered request valid
arb_l2req  out  613  registered packed request, same layout; downstream slices fields
arb_has_sm_data  out  1  registered: request is a restart carrying fill data
arb_sm_data  out  512  registered fill data
arb_sm_fill_l2_way  out  2  registered fill way

Behaviour:
- Reset: when reset_n=0 at a clk edge, all registered outputs and starve_cnt go to 0. pci_ack and smi_ack are 0 during reset. Reset overrides stall_pipeline.
- starve_cnt: 4-bit saturating counter.
- Grant is combinational each cycle:
  - stall_pipeline=1: no grant.
  - Else, if smi_valid and not (pci_valid and starve_cnt==STARVE_LIMIT): grant restart.
  - Else, if pci_valid: grant core.
  - Else: idle.
- Acks: pci_ack = grant core; smi_ack = grant restart. Acks are combinational, single-cycle, and never both 1. Requester holds valid and payload stable until acked; after the ack it may present a new request in the next cycle.
- Output register updates only when stall_pipeline=0. Latency is 1 cycle from grant to arb_* valid.
  - Restart granted: arb_l2req_valid=1, arb_l2req=smi_request, arb_has_sm_data=1, arb_sm_data=smi_data, arb_sm_fill_l2_way=smi_fill_l2_way.
  - Core granted: arb_l2req_valid=1, arb_l2req=pci_request, arb_has_sm_data=0. arb_sm_data and fill_way load 0.
  - Idle: arb_l2req_valid=0, arb_has_sm_data=0, payload registers hold previous values.
- Stall: every output register holds its value; starve_cnt holds; no ack.
- starve_cnt update, unstalled cycles only:
  - Restart granted while pci_valid=1: starve_cnt+1, saturating at STARVE_LIMIT.
  - Core granted, or pci_valid=0: starve_cnt=0.
- Boundary cases:
  - starve_cnt==STARVE_LIMIT with both valid: core wins, counter clears, and the next cycle returns to restart priority.
  - Only smi_valid at the limit: restart is granted. This cannot occur in practice, because the counter clears whenever pci_valid=0.
  - Reset asserted mid-stall: outputs clear, and the pending requester is re-arbitrated after reset_n rises.
- Op field contents are not checked. A restart carrying a flush/invalidate op is a source-side error flagged downstream.

Optional Feature:
- Macro L2_ARB_PERF_EN.
- Defined: adds outputs perf_restart_grants[31:0], perf_core_grants[31:0] and perf_starve_events[31:0].
  - restart/core counters increment once per corresponding ack.
  - perf_starve_events increments when core wins because starve_cnt==STARVE_LIMIT.
  - All three wrap modulo 2^32 and clear on reset.
- Undefined: these ports and registers do not exist; grant behaviour is identical.

Test Plan:
1. Reset with both valids high → arb_l2req_valid=0, arb_has_sm_data=0, no acks; one cycle after reset_n=1 → smi_ack=1 and arb_has_sm_data=1 in the following cycle.
2. pci_valid alone, address=26'h0000123 → pci_ack=1 the same cycle; next cycle arb_l2req_valid=1, address field=26'h0000123, arb_has_sm_data=0.
3. Both valid continuously, STARVE_LIMIT=4 → grant sequence R,R,R,R,C,R,R,R,R,C…; exactly one pci_ack per 5 grants.
4. stall_pipeline=1 for 3 cycles with both valid → acks 0, arb_* unchanged, starve_cnt unchanged; on release arbitration resumes from the held count.
5. Restart with smi_fill_l2_way=2'd3 and smi_data=512'hA5… → arb_sm_fill_l2_way=3 and arb_sm_data=A5… one cycle after smi_ack.
6. With L2_ARB_PERF_EN defined, scenario 3 run for 10 grants → perf_restart_grants=8, perf_core_grants=2, perf_starve_events=2.
